// File: rtl/wb_result_fifo.sv
// wb_result_fifo
// Buffers the write-back result stream of the pipelined core. Each entry is
// {flag, salida}. The consumer reads it through a first-word-fall-through
// valid/ready handshake. The core never stalls, so a word that arrives while
// the FIFO is full and no pop happens is dropped and recorded in a sticky
// overflow flag.
// Optional build macro: WB_FIFO_STATS_EN adds the drop_cnt and high_wm
// statistics outputs.
module wb_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] salida,
  input  logic              flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_flag,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  input  logic              clr_ovf
`ifdef WB_FIFO_STATS_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic [ADDR_W:0]   high_wm
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO  = (ADDR_W+1)'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO  = ADDR_W'(0);

  // Storage and pointers
  logic [DATA_W:0]   mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_next_s;
  logic              valid_r;
  logic              full_r;
  logic              overflow_r;
  logic              overflow_next_s;

  // Handshake decode
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic [DATA_W:0]   head_s;

  // Decode push/pop/drop from registered occupancy and the live handshake.
  always_comb begin
    pop_s  = valid_r & out_ready;
    push_s = in_valid & (~full_r | pop_s);
    drop_s = in_valid & full_r & ~pop_s;
  end

  // Next occupancy: +1 on push only, -1 on pop only, otherwise held.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Sticky overflow: a drop this cycle overrides a simultaneous clear.
  always_comb begin
    overflow_next_s = overflow_r;
    if (drop_s) begin
      overflow_next_s = 1'b1;
    end else if (clr_ovf) begin
      overflow_next_s = 1'b0;
    end else begin
      overflow_next_s = overflow_r;
    end
  end

  // Entry storage; written only on an accepted push, so drops leave it intact.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {flag, salida};
    end
  end

  // Pointers, occupancy and status flags, all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      valid_r    <= 1'b0;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_next_s;
      valid_r    <= (count_next_s != CNT_ZERO);
      full_r     <= (count_next_s == DEPTH_C);
      overflow_r <= overflow_next_s;
    end
  end

  // Head entry as seen by the consumer; forced to zero while empty.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (valid_r) begin
      out_data = head_s[DATA_W-1:0];
      out_flag = head_s[DATA_W];
    end else begin
      out_data = {DATA_W{1'b0}};
      out_flag = 1'b0;
    end
  end

  assign out_valid = valid_r;
  assign count     = count_r;
  assign full      = full_r;
  assign overflow  = overflow_r;

`ifdef WB_FIFO_STATS_EN
  logic [15:0]     drop_cnt_r;
  logic [15:0]     drop_cnt_next_s;
  logic [ADDR_W:0] high_wm_r;

  // Saturating drop counter; a drop this cycle overrides a simultaneous clear.
  always_comb begin
    drop_cnt_next_s = drop_cnt_r;
    if (drop_s) begin
      if (drop_cnt_r != 16'hFFFF) begin
        drop_cnt_next_s = drop_cnt_r + 16'd1;
      end else begin
        drop_cnt_next_s = drop_cnt_r;
      end
    end else if (clr_ovf) begin
      drop_cnt_next_s = 16'd0;
    end else begin
      drop_cnt_next_s = drop_cnt_r;
    end
  end

  // Statistics registers: drop count and peak occupancy since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= 16'd0;
      high_wm_r  <= CNT_ZERO;
    end else begin
      drop_cnt_r <= drop_cnt_next_s;
      if (count_next_s > high_wm_r) begin
        high_wm_r <= count_next_s;
      end
    end
  end

  assign drop_cnt = drop_cnt_r;
  assign high_wm  = high_wm_r;
`endif

endmodule

// File: tb/tb_wb_result_fifo.sv
// Directed bench for wb_result_fifo with a queue scoreboard of expected
// {flag, word} entries.
module tb_wb_result_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] salida = 32'd0;
  logic        flag = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_flag;
  logic [4:0]  count;
  logic        full;
  logic        overflow;
  logic        clr_ovf = 1'b0;
`ifdef WB_FIFO_STATS_EN
  logic [15:0] drop_cnt;
  logic [4:0]  high_wm;
`endif

  int errors = 0;
  int checks = 0;
  logic [32:0] sb[$];
  logic ovf_m = 1'b0;
  int   drop_m = 0;
  int   hwm_m = 0;

  wb_result_fifo #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .salida(salida), .flag(flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flag(out_flag), .count(count), .full(full), .overflow(overflow),
    .clr_ovf(clr_ovf)
`ifdef WB_FIFO_STATS_EN
    , .drop_cnt(drop_cnt), .high_wm(high_wm)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check head, update model, check state.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic f,
                     input logic rdy, input logic clr);
    logic pop_m, push_m, drop_e;
    in_valid = iv; salida = d; flag = f; out_ready = rdy; clr_ovf = clr;
    #1;
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("head_data", 64'(out_data), 64'(sb[0][31:0]));
      chk("head_flag", 64'(out_flag), 64'(sb[0][32]));
    end else begin
      chk("empty_out", 64'({out_flag, out_data}), 64'd0);
    end
    pop_m  = rdy && (sb.size() != 0);
    push_m = iv && ((sb.size() < 16) || pop_m);
    drop_e = iv && (sb.size() == 16) && !pop_m;
    if (pop_m) void'(sb.pop_front());
    if (push_m) sb.push_back({f, d});
    if (drop_e) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    if (drop_e) drop_m = (drop_m == 65535) ? 65535 : drop_m + 1;
    else if (clr) drop_m = 0;
    if (sb.size() > hwm_m) hwm_m = sb.size();
    @(posedge clk);
    #1;
    chk("count", 64'(count), 64'(sb.size()));
    chk("full", 64'(full), 64'(sb.size() == 16));
    chk("overflow", 64'(overflow), 64'(ovf_m));
`ifdef WB_FIFO_STATS_EN
    chk("drop_cnt", 64'(drop_cnt), 64'(drop_m));
    chk("high_wm", 64'(high_wm), 64'(hwm_m));
`endif
  endtask

  initial begin
    // 1: reset then idle
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // 2: two pushes, consumer stalled; latency of one cycle to out_valid
    cyc(1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0); // last one pops an empty FIFO

    // 3: fill 16, then three dropped words, then drain in order
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_00AA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_00AB, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_00AC, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    // 4: full with simultaneous push+pop, then drop racing clear
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'(100 + i), i[0], 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0077, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h0000_0088, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

    // 5: continuous push+pop across pointer wraps
    for (int i = 0; i < 40; i++) cyc(1'b1, 32'(1000 + i), i[0], 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

    // 6: asynchronous reset mid-stream with nine entries stored
    for (int i = 0; i < 9; i++) cyc(1'b1, 32'(200 + i), 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_full", 64'(full), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_data", 64'({out_flag, out_data}), 64'd0);
    sb.delete();
    ovf_m = 1'b0; drop_m = 0; hwm_m = 0;
    #1;
    rst = 1'b0;
    cyc(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
